aes_pad_host: RTL and testbench
===============================

# aes_pad_host

Host-side bus master for the packaged AES chip's pad interface. Accepts a 32-byte frame (16 key bytes, then 16 plaintext bytes) on a byte stream. Writes the frame into the chip through WR/ADDR/DIN, pulses START, and waits for OK. It then reads the 16 ciphertext bytes back over ADDR/DOUT and emits them on an output byte stream. It sits in the FPGA test harness and drives the chip's pins directly.

## Interface
Parameters:
- KEY_BASE, 7'h00, chip address of key byte 0
- PT_BASE, 7'h10, chip address of plaintext byte 0
- CT_BASE, 7'h20, chip address of ciphertext byte 0
- READ_LAT, 2, cycles from CHIP_ADDR driven to CHIP_DOUT sampled (≥1)
- TIMEOUT, 4096, maximum WAIT cycles before abort (≥4)

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  input byte valid
- IN_READY  out  1  input byte accepted when IN_VALID&IN_READY
- IN_DATA  in  8  key/plaintext byte
- OUT_VALID  out  1  ciphertext byte valid
- OUT_READY  in  1  downstream accepts
- OUT_DATA  out  8  ciphertext byte
- BUSY  out  1  high in any state except IDLE
- ERR  out  1  sticky timeout flag; cleared by first input handshake of next frame or RST
- CHIP_START  out  1  to chip START pad
- CHIP_WR  out  1  to chip WR pad
- CHIP_ADDR  out  7  to chip ADDR pads
- CHIP_DIN  out  8  to chip DIN pads
- CHIP_OK  in  1  from chip OK pad; asynchronous to logic, 2-flop synchronized
- CHIP_DOUT  in  8  from chip DOUT pads

## Operation
- States: IDLE, WRITE, START, WAIT, READ, SEND.
- Reset values: state IDLE, byte index 0, CHIP_START/CHIP_WR 0, CHIP_ADDR/CHIP_DIN 0, OUT_VALID 0, OUT_DATA 0, ERR 0, BUSY 0. RST in any state, including mid-frame, aborts with no further chip traffic. Synchronizer flops reset to 0.
- IN_READY = 1 in IDLE and WRITE, 0 elsewhere.
- IDLE: first handshake enters WRITE with index 0 and clears ERR.
- WRITE: each handshake of byte i (0..31) registers CHIP_WR=1, CHIP_DIN=byte, and CHIP_ADDR, all driven the next cycle.
  - CHIP_ADDR = KEY_BASE+i for i<16; PT_BASE+(i-16) for i≥16.
  - A cycle without a handshake drives CHIP_WR=0 and holds CHIP_ADDR/CHIP_DIN.
  - Back-to-back bytes give one write per cycle.
  - After byte 31 the state goes to START; IN_READY drops that same cycle.
- START: CHIP_WR=0 and CHIP_START=1 for exactly one cycle, then WAIT. Timeout counter cleared.
- WAIT: the counter increments each cycle.
  - Synced OK must first be seen 0 and then 1; a stale high OK from the previous frame is ignored until it falls.
  - On the qualifying rising edge: go to READ with k=0.
  - If the counter reaches TIMEOUT first: set ERR=1 and return to IDLE. No output bytes are produced.
- READ: drive CHIP_ADDR=CT_BASE+k with CHIP_WR=0. After READ_LAT cycles, capture CHIP_DOUT into OUT_DATA, set OUT_VALID=1, and go to SEND.
- SEND: hold OUT_VALID/OUT_DATA until OUT_READY. On the handshake, OUT_VALID=0 next cycle.
  - If k<15: k+1, back to READ.
  - If k=15: go to IDLE.
- Address arithmetic is 7-bit, wrapping modulo 128. Index counters are 5-bit (write) and 4-bit (read).
- OUT_READY held low indefinitely stalls in SEND; no timeout applies there.

## Timing
- Write of byte i appears on the pins 1 cycle after its handshake.
- With continuous IN_VALID, the 32 writes occupy 32 consecutive cycles. CHIP_START is high on the cycle immediately after the last write.
- OK recognition latency is 2 cycles (synchronizer) plus 1 cycle for the state transition.
- Read byte k: CHIP_ADDR is stable from READ entry. OUT_VALID rises READ_LAT+1 cycles after entry.
- With OUT_READY tied high, the per-byte period is READ_LAT+2 cycles.
- Frame-to-frame: the next frame's first handshake can occur the cycle after IDLE is re-entered.

## Test plan
- Reset, then 32 bytes 0x00..0x1F with IN_VALID held high; chip model raises OK 20 cycles after START, CT bytes = 0xA0..0xAF.
  - Writes go to addr 0x00..0x0F then 0x10..0x1F on 32 consecutive cycles, and CHIP_START is a single-cycle pulse.
  - OUT_DATA is 0xA0..0xAF in order, and ERR stays 0.
- Same frame with IN_VALID toggling randomly and OUT_READY low for 5 cycles on byte 7.
  - Identical chip write sequence (gaps allowed) and identical output.
  - OUT_DATA is held stable through the stall.
- OK never rises.
  - ERR=1 exactly TIMEOUT cycles after WAIT entry, with zero OUT_VALID pulses and return to IDLE.
  - The next frame's first byte clears ERR.
- OK left high from the previous frame and falls 3 cycles after START.
  - No read begins until OK rises again.
- RST asserted during WRITE (byte 10), then during SEND (byte 5).
  - All outputs return to reset values next cycle.
  - A fresh frame then completes normally, starting at address 0x00.
- READ_LAT=1 and READ_LAT=4 builds.
  - CHIP_DOUT is sampled exactly READ_LAT cycles after CHIP_ADDR changes; a model returning addr^0x55 yields the correct bytes.

Source files
------------

// File: rtl/aes_pad_host.sv
// aes_pad_host: host bus master that loads key/plaintext into the AES chip pads, starts it and streams back the ciphertext
module aes_pad_host #(
    parameter logic [6:0] KEY_BASE = 7'h00,
    parameter logic [6:0] PT_BASE  = 7'h10,
    parameter logic [6:0] CT_BASE  = 7'h20,
    parameter int         READ_LAT = 2,
    parameter int         TIMEOUT  = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [7:0] IN_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] OUT_DATA,
    output logic       BUSY,
    output logic       ERR,
    output logic       CHIP_START,
    output logic       CHIP_WR,
    output logic [6:0] CHIP_ADDR,
    output logic [7:0] CHIP_DIN,
    input  logic       CHIP_OK,
    input  logic [7:0] CHIP_DOUT
);
    localparam int RW = $clog2(READ_LAT + 1) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [RW-1:0] RL = RW'(READ_LAT);
    localparam logic [TW-1:0] TL = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, START, WAIT, READ, SEND} state_t;

    state_t        state;
    logic [4:0]    widx;
    logic [3:0]    ridx;
    logic [RW-1:0] rc;
    logic [TW-1:0] tcnt;
    logic          ok_s1, ok_s2, armed;
    logic          hs;
    logic [6:0]    waddr;

    assign IN_READY = (state == IDLE) || (state == WRITE);
    assign BUSY     = state != IDLE;
    assign hs       = IN_VALID && IN_READY;
    // widx is 0 whenever IDLE, so the first byte of a frame shares the write path
    assign waddr    = (widx[4] ? PT_BASE : KEY_BASE) + {3'b000, widx[3:0]};

    // two-flop synchronizer for the asynchronous OK pad
    always_ff @(posedge CLK) begin
        if (RST) begin
            ok_s1 <= 1'b0;
            ok_s2 <= 1'b0;
        end else begin
            ok_s1 <= CHIP_OK;
            ok_s2 <= ok_s1;
        end
    end

    // frame sequencer: write 32 bytes, pulse start, wait for a fresh OK edge, read 16 bytes
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            widx       <= '0;
            ridx       <= '0;
            rc         <= '0;
            tcnt       <= '0;
            armed      <= 1'b0;
            CHIP_START <= 1'b0;
            CHIP_WR    <= 1'b0;
            CHIP_ADDR  <= '0;
            CHIP_DIN   <= '0;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            ERR        <= 1'b0;
        end else begin
            CHIP_WR    <= 1'b0;
            CHIP_START <= 1'b0;
            case (state)
                IDLE, WRITE: if (hs) begin
                    CHIP_WR   <= 1'b1;
                    CHIP_ADDR <= waddr;
                    CHIP_DIN  <= IN_DATA;
                    widx      <= widx + 5'd1;
                    if (state == IDLE) begin
                        ERR   <= 1'b0;
                        state <= WRITE;
                    end
                    if (widx == 5'd31) state <= START;
                end
                START: begin
                    CHIP_START <= 1'b1;
                    tcnt       <= '0;
                    armed      <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // OK must be seen low before a high counts, so a stale OK is ignored
                    if (!ok_s2) armed <= 1'b1;
                    if (armed && ok_s2) begin
                        ridx  <= '0;
                        rc    <= '0;
                        state <= READ;
                    end else if (tcnt == TL) begin
                        ERR   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                READ: begin
                    if (rc == '0) CHIP_ADDR <= CT_BASE + {3'b000, ridx};
                    if (rc == RL) begin
                        OUT_DATA  <= CHIP_DOUT;
                        OUT_VALID <= 1'b1;
                        state     <= SEND;
                    end else begin
                        rc <= rc + 1'b1;
                    end
                end
                SEND: if (OUT_READY) begin
                    OUT_VALID <= 1'b0;
                    rc        <= '0;
                    ridx      <= ridx + 4'd1;
                    state     <= (ridx == 4'd15) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_pad_host.sv
// tb_aes_pad_host: frame-level checks of aes_pad_host against a behavioural chip and frame model
module tb_aes_pad_host #(
    parameter int RL = 2
);
    localparam logic [6:0] KB = 7'h00;
    localparam logic [6:0] PB = 7'h10;
    localparam logic [6:0] CB = 7'h20;
    localparam int TO = 200;
    localparam int HI = (RL >= 2) ? RL - 2 : 0;

    typedef struct {
        int vprob;
        int stall_k;
        int stall_n;
        int ok_fall;
        int ok_rise;
        int mode;
        int rnd;
    } scen_t;

    logic       clk = 0;
    logic       rst = 1;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in_data = 0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [7:0] out_data;
    logic       busy, err, chip_start, chip_wr;
    logic [6:0] chip_addr;
    logic [7:0] chip_din;
    logic       chip_ok = 0;
    logic [7:0] chip_dout;

    aes_pad_host #(
        .KEY_BASE(KB), .PT_BASE(PB), .CT_BASE(CB), .READ_LAT(RL), .TIMEOUT(TO)
    ) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .BUSY(busy), .ERR(err), .CHIP_START(chip_start), .CHIP_WR(chip_wr),
        .CHIP_ADDR(chip_addr), .CHIP_DIN(chip_din), .CHIP_OK(chip_ok), .CHIP_DOUT(chip_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // test control, written only by the main sequence
    int frame_id = 0;
    int stall_k = -1, stall_n = 0, ok_fall = 1, ok_rise = 20, ct_mode = 0;
    logic [7:0] fb [32];
    int n_chk = 0, n_fail = 0;

    // chip model: DOUT presents the byte for the address driven RL-1 cycles ago,
    // so a sample taken exactly RL cycles after the address change sees it
    logic [6:0] hist [8];
    logic [6:0] da;
    always @(posedge clk) begin
        for (int j = 7; j > 0; j--) hist[j] <= hist[j-1];
        hist[0] <= chip_addr;
    end
    assign da = (RL == 1) ? chip_addr : hist[HI];
    always_comb chip_dout = (ct_mode != 0) ? ({1'b0, da} ^ 8'h55)
                          : ((da >= CB && da < CB + 7'd16) ? 8'hA0 + {1'b0, da - CB} : 8'hEE);

    // monitor state, written only by the monitor process
    int wq_a[$], wq_d[$], oq[$], oc[$];
    int mon_id = 0, first_wr, last_wr, first_hs, n_hs, n_start, start_cyc, first_ov, err_rise, stall_bad;
    int err1;
    bit start_seen, ov_prev, or_prev, err_prev, rst_prev;
    logic [7:0] od_prev;

    initial forever begin
        @(negedge clk);
        if (mon_id != frame_id) begin
            mon_id = frame_id;
            wq_a.delete(); wq_d.delete(); oq.delete(); oc.delete();
            first_wr = -1; last_wr = -1; first_hs = -1; n_hs = 0; n_start = 0;
            start_cyc = -1; first_ov = -1; err_rise = -1; stall_bad = 0; err1 = -1;
            start_seen = 0;
        end
        if (chip_wr) begin
            wq_a.push_back(int'(chip_addr));
            wq_d.push_back(int'(chip_din));
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (chip_start) begin
            n_start++;
            start_cyc = cyc;
            start_seen = 1;
        end
        if (in_valid && in_ready) begin
            if (n_hs == 0) first_hs = cyc;
            n_hs++;
        end
        if (n_hs > 0 && cyc == first_hs + 1) err1 = int'(err);
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (!rst_prev && ov_prev && !or_prev && (!out_valid || out_data != od_prev)) stall_bad++;
        if (out_valid && out_ready) begin
            oq.push_back(int'(out_data));
            oc.push_back(cyc);
        end
        if (err && !err_prev) err_rise = cyc;
        ov_prev = out_valid; or_prev = out_ready; od_prev = out_data; err_prev = err; rst_prev = rst;
    end

    // chip OK pad: falls and rises a configured number of cycles after the START pulse
    int rise_cyc = -1;
    initial forever begin
        @(posedge clk);
        #1;
        if (start_seen) begin
            if (cyc == start_cyc + ok_fall) chip_ok = 0;
            if (ok_rise >= 0 && cyc == start_cyc + ok_rise) begin
                chip_ok = 1;
                rise_cyc = cyc;
            end
        end
    end

    // downstream: stalls byte stall_k for stall_n cycles, otherwise always ready
    initial begin
        int rid, scnt;
        rid = 0; scnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rid != frame_id) begin
                rid = frame_id;
                scnt = 0;
            end
            if (out_valid && oq.size() == stall_k && scnt < stall_n) begin
                out_ready = 0;
                scnt++;
            end else begin
                out_ready = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_frame(input int vprob, input int abort_at);
        int i, n;
        i = 0; n = 0;
        while (i < 32 && n < 2000) begin
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                in_valid = 0;
                rst = 1;
                return;
            end
            in_valid = ($urandom_range(99) < vprob);
            in_data = fb[i];
            @(negedge clk);
            n++;
            if (in_valid && in_ready) i++;
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        check("bytes_accepted", i, 32);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(!busy && (oq.size() == 16 || err)) && n < budget);
        n_chk++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL frame_done: still busy after %0d cycles, required fewer", n);
        end
    endtask

    task automatic prep(input scen_t s);
        for (int i = 0; i < 32; i++) fb[i] = (s.rnd != 0) ? 8'($urandom) : 8'(i);
        stall_k = s.stall_k; stall_n = s.stall_n;
        ok_fall = s.ok_fall; ok_rise = s.ok_rise; ct_mode = s.mode;
        frame_id++;
    endtask

    task automatic check_frame(input scen_t s);
        int ea, ed, bad;
        check("wr_count", wq_a.size(), 32);
        for (int i = 0; i < 32; i++) begin
            ea = ((i < 16) ? int'(KB) + i : int'(PB) + i - 16) % 128;
            check($sformatf("wr_addr[%0d]", i), (i < wq_a.size()) ? wq_a[i] : -1, ea);
            check($sformatf("wr_data[%0d]", i), (i < wq_d.size()) ? wq_d[i] : -1, int'(fb[i]));
        end
        check("start_pulses", n_start, 1);
        check("out_count", oq.size(), 16);
        for (int k = 0; k < 16; k++) begin
            ed = (s.mode != 0) ? (((int'(CB) + k) % 128) ^ 'h55) : ('hA0 + k);
            check($sformatf("out_data[%0d]", k), (k < oq.size()) ? oq[k] : -1, ed);
        end
        check("err_clear", err, 0);
        check("busy_idle", busy, 0);
        check("first_out_latency", first_ov - rise_cyc, RL + 4);
        check("stall_hold", stall_bad, 0);
        if (s.vprob >= 100) begin
            check("wr_first_latency", first_wr - first_hs, 1);
            check("wr_consecutive", last_wr - first_wr, 31);
            check("start_after_last_wr", start_cyc - last_wr, 1);
        end
        if (s.stall_n == 0) begin
            bad = 0;
            for (int k = 1; k < oc.size(); k++) if (oc[k] - oc[k-1] != RL + 2) bad++;
            check("out_period", bad, 0);
        end
    endtask

    task automatic run_frame(input scen_t s);
        prep(s);
        send_frame(s.vprob, -1);
        wait_done(3000);
        check_frame(s);
    endtask

    task automatic check_reset(input string name);
        @(posedge clk);
        @(negedge clk);
        check(name, {busy, err, out_valid, out_data, chip_start, chip_wr, chip_addr, chip_din, ~in_ready}, 0);
        rst = 0;
    endtask

    initial begin
        scen_t tbl[5];
        scen_t s;
        int n;
        tbl[0] = '{100, -1, 0, 1, 20, 0, 0};
        tbl[1] = '{50, 7, 5, 1, 20, 0, 0};
        tbl[2] = '{70, 3, 2, 1, 9, 1, 1};
        tbl[3] = '{100, 15, 3, 1, 5, 1, 1};
        tbl[4] = '{30, -1, 0, 1, 30, 0, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {busy, err, out_valid, out_data, chip_start, chip_wr, chip_addr, chip_din, ~in_ready}, 0);
        rst = 0;

        for (int t = 0; t < 5; t++) run_frame(tbl[t]);
        for (int t = 0; t < 3; t++) begin
            s = '{int'($urandom_range(20, 100)), int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                  1, int'($urandom_range(5, 40)), int'($urandom_range(0, 1)), 1};
            run_frame(s);
        end

        // OK still high from the previous frame, falls 3 cycles after START, rises at 14
        s = '{100, -1, 0, 3, 14, 0, 1};
        run_frame(s);

        // OK never rises: abort with ERR after exactly TO cycles of WAIT
        s = '{100, -1, 0, 1, -1, 0, 1};
        prep(s);
        send_frame(100, -1);
        wait_done(TO + 200);
        check("timeout_err", err, 1);
        check("timeout_cycles", err_rise - start_cyc, TO);
        check("timeout_no_output", oq.size(), 0);
        check("timeout_idle", busy, 0);

        // next frame clears ERR on its first byte
        s = '{100, -1, 0, 1, 20, 1, 1};
        prep(s);
        check("err_before_next", err, 1);
        send_frame(100, -1);
        wait_done(3000);
        check("err_cleared_first_byte", err1, 0);
        check_frame(s);

        // reset mid-WRITE at byte 10, then a clean frame
        s = '{100, -1, 0, 1, 20, 0, 0};
        prep(s);
        send_frame(100, 10);
        check_reset("reset_in_write");
        run_frame(s);

        // reset mid-SEND at byte 5 (held by a long stall), then a clean frame
        s = '{100, 5, 1000, 1, 20, 0, 1};
        prep(s);
        send_frame(100, -1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(oq.size() == 5 && out_valid) && n < 1000);
        check("reach_send_byte5", n < 1000, 1);
        @(posedge clk);
        #1;
        rst = 1;
        check_reset("reset_in_send");
        s = '{100, -1, 0, 1, 20, 1, 1};
        run_frame(s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
